// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port 16x8 data memory between the core
// (fixed priority) and a host debug/DMA port. Zero-latency req/gnt
// arbitration, a bounded host wait counter, a host lock mode for bursts,
// and read-data routing back to the requester one cycle after the grant.
module dmem_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_e,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  input  logic [DATA_W-1:0] mem_do
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] HOST_LOCK = 1'b1;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_nxt;
  logic       rd_pend;
  logic       rd_owner;

  // Grant decision: core has priority unless the host has waited MAX_WAIT
  // cycles; in lock mode the host owns the memory outright. Grants are
  // suppressed while reset is asserted.
  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (!rst) begin
      if (state == HOST_LOCK) begin
        host_gnt = host_req;
      end else if (core_req && host_req) begin
        if (wait_cnt == MAX_W) begin
          host_gnt = 1'b1;
        end else begin
          core_gnt = 1'b1;
        end
      end else begin
        core_gnt = core_req;
        host_gnt = host_req;
      end
    end
  end

  // Memory port mux from whichever requester holds the grant; idle drives zeros.
  always_comb begin
    mem_e    = core_gnt | host_gnt;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_di   = '0;
    if (core_gnt) begin
      mem_we   = core_we;
      mem_addr = core_addr;
      mem_di   = core_wdata;
    end else if (host_gnt) begin
      mem_we   = host_we;
      mem_addr = host_addr;
      mem_di   = host_wdata;
    end
  end

  // Next-state and wait-counter logic. The host's final (unlocked) grant
  // still wins its cycle; the core is eligible again from the next one.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    if (state == HOST_LOCK) begin
      if (!host_req || (host_gnt && !host_lock)) begin
        state_nxt = IDLE;
      end
    end else begin
      if (host_gnt && host_lock) begin
        state_nxt = HOST_LOCK;
      end
      if (!host_req || host_gnt) begin
        wait_cnt_nxt = '0;
      end else if (wait_cnt < MAX_W) begin
        wait_cnt_nxt = wait_cnt + 4'd1;
      end
    end
  end

  // Control state: FSM, wait counter and the one-deep read-return tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      rd_pend  <= (core_gnt && !core_we) || (host_gnt && !host_we);
      rd_owner <= host_gnt;
    end
  end

  // Read return: route the registered memory output to the read's owner.
  // Gated by rst so a read granted just before reset never returns.
  always_comb begin
    core_rvalid = rd_pend && !rd_owner && !rst;
    host_rvalid = rd_pend && rd_owner && !rst;
    core_rdata  = core_rvalid ? mem_do : '0;
    host_rdata  = host_rvalid ? mem_do : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural 16x8 registered-read memory.
module tb_dmem_arbiter;

  logic       clk;
  logic       rst;
  logic       core_req, core_we;
  logic [3:0] core_addr;
  logic [7:0] core_wdata;
  logic       core_gnt, core_rvalid;
  logic [7:0] core_rdata;
  logic       host_req, host_we, host_lock;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic       mem_e, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_di;
  logic [7:0] mem_do;

  logic [7:0] mem [16];

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.ADDR_W(4), .DATA_W(8), .MAX_WAIT(3)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_lock(host_lock), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_e(mem_e), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
    .mem_do(mem_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory, registered read.
  always_ff @(posedge clk) begin
    if (mem_e) begin
      if (mem_we) mem[mem_addr] <= mem_di;
      else        mem_do <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem_do = 8'h00;
    rst = 1'b1;
    core_req = 1'b1; core_we = 1'b1; core_addr = 4'd3; core_wdata = 8'hA5;
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd3; host_wdata = 8'h00;
    host_lock = 1'b0;

    // Reset held two cycles with both requests high
    tick(); #1;
    chk("rst1_core_gnt", 32'(core_gnt), 0);
    chk("rst1_host_gnt", 32'(host_gnt), 0);
    chk("rst1_mem_e", 32'(mem_e), 0);
    tick(); #1;
    chk("rst2_core_gnt", 32'(core_gnt), 0);
    chk("rst2_host_gnt", 32'(host_gnt), 0);
    chk("rst2_rvalid", 32'({core_rvalid, host_rvalid}), 0);
    chk("rst2_mem_addr", 32'(mem_addr), 0);

    // Release: core wins first cycle, writes 0xA5 to addr 3
    tick(); rst = 1'b0; #1;
    chk("rel_core_gnt", 32'(core_gnt), 1);
    chk("rel_host_gnt", 32'(host_gnt), 0);
    chk("rel_mem", 32'({mem_we, mem_addr, mem_di}), 32'({1'b1, 4'd3, 8'hA5}));

    // Host-only read of addr 3
    tick(); core_req = 1'b0; #1;
    chk("hrd_host_gnt", 32'(host_gnt), 1);
    chk("hrd_mem", 32'({mem_e, mem_we, mem_addr}), 32'({1'b1, 1'b0, 4'd3}));
    tick(); host_req = 1'b0; #1;
    chk("hrd_host_rvalid", 32'(host_rvalid), 1);
    chk("hrd_host_rdata", 32'(host_rdata), 32'h A5);
    chk("hrd_core_rvalid", 32'({core_rvalid, core_rdata}), 0);
    chk("hrd_idle_mem_e", 32'(mem_e), 0);

    // Starvation bound: both request continuously from T
    tick(); core_req = 1'b1; core_we = 1'b0; core_addr = 4'd0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd3; #1;
    chk("st0_wait", 32'(dut.wait_cnt), 0);
    chk("st0_core_gnt", 32'(core_gnt), 1);
    tick(); #1;
    chk("st1_core_gnt", 32'(core_gnt), 1);
    chk("st1_core_rvalid", 32'(core_rvalid), 1);
    chk("st1_core_rdata", 32'(core_rdata), 0);
    tick(); #1;
    chk("st2_gnts", 32'({core_gnt, host_gnt}), 32'b10);
    chk("st2_wait", 32'(dut.wait_cnt), 2);
    tick(); #1;
    chk("st3_gnts", 32'({core_gnt, host_gnt}), 32'b01);
    chk("st3_wait", 32'(dut.wait_cnt), 3);
    tick(); #1;
    chk("st4_gnts", 32'({core_gnt, host_gnt}), 32'b10);
    chk("st4_wait", 32'(dut.wait_cnt), 0);
    chk("st4_host_rvalid", 32'(host_rvalid), 1);
    chk("st4_host_rdata", 32'(host_rdata), 32'h A5);
    tick(); core_req = 1'b0; host_req = 1'b0; #1;

    // Lock burst: host writes addr 0..3, data i*0x11
    tick(); host_req = 1'b1; host_we = 1'b1; host_addr = 4'd0; host_wdata = 8'h00;
    host_lock = 1'b1; #1;
    chk("lk0_host_gnt", 32'(host_gnt), 1);
    tick(); core_req = 1'b1; core_we = 1'b0; core_addr = 4'd1;
    host_addr = 4'd1; host_wdata = 8'h11; #1;
    chk("lk1_gnts", 32'({core_gnt, host_gnt}), 32'b01);
    chk("lk1_state", 32'(dut.state), 1);
    tick(); host_addr = 4'd2; host_wdata = 8'h22; #1;
    chk("lk2_gnts", 32'({core_gnt, host_gnt}), 32'b01);
    tick(); host_addr = 4'd3; host_wdata = 8'h33; host_lock = 1'b0; #1;
    chk("lk3_gnts", 32'({core_gnt, host_gnt}), 32'b01);
    chk("lk3_mem", 32'({mem_we, mem_addr, mem_di}), 32'({1'b1, 4'd3, 8'h33}));
    tick(); host_req = 1'b0; #1;
    chk("lk4_core_gnt", 32'(core_gnt), 1);
    chk("lk4_state", 32'(dut.state), 0);

    // Interleaved reads: core addr1 (0x11) / host addr2 (0x22)
    tick(); core_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 4'd2; #1;
    chk("il0_host_gnt", 32'(host_gnt), 1);
    chk("il0_core_ret", 32'({core_rvalid, host_rvalid, core_rdata}), 32'({2'b10, 8'h11}));
    tick(); host_req = 1'b0; core_req = 1'b1; core_addr = 4'd1; #1;
    chk("il1_core_gnt", 32'(core_gnt), 1);
    chk("il1_host_ret", 32'({core_rvalid, host_rvalid, host_rdata}), 32'({2'b01, 8'h22}));
    tick(); core_req = 1'b0; host_req = 1'b1; #1;
    chk("il2_core_ret", 32'({core_rvalid, host_rvalid, core_rdata}), 32'({2'b10, 8'h11}));
    tick(); host_req = 1'b0; #1;
    chk("il3_host_ret", 32'({core_rvalid, host_rvalid, host_rdata}), 32'({2'b01, 8'h22}));

    // Reset mid-read: read granted, rst asserted next cycle
    tick(); core_req = 1'b1; core_we = 1'b0; core_addr = 4'd1; #1;
    chk("rm0_core_gnt", 32'(core_gnt), 1);
    tick(); rst = 1'b1; core_req = 1'b0; #1;
    chk("rm1_core_ret", 32'({core_rvalid, core_rdata}), 0);
    tick(); rst = 1'b0; #1;
    chk("rm2_core_rvalid", 32'(core_rvalid), 0);
    chk("rm2_state", 32'(dut.state), 0);

    // Reset drops a lock in progress
    tick(); host_req = 1'b1; host_we = 1'b1; host_addr = 4'd5; host_wdata = 8'h55;
    host_lock = 1'b1; #1;
    chk("rl0_host_gnt", 32'(host_gnt), 1);
    tick(); rst = 1'b1; #1;
    chk("rl1_host_gnt", 32'(host_gnt), 0);
    tick(); rst = 1'b0; core_req = 1'b1; #1;
    chk("rl2_state", 32'(dut.state), 0);
    chk("rl2_gnts", 32'({core_gnt, host_gnt}), 32'b10);

    tick(); core_req = 1'b0; host_req = 1'b0; host_lock = 1'b0; #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
